dmem_sram_ctrl: RTL

//  Data-memory responder: the slave end of the MEM-stage dm_* interface. Converts each load/store into a timed

---
 rtl/dmem_sram_ctrl_pkg.sv | 31 +++
 rtl/dmem_sram_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_ctrl_pkg.sv
// Shared types and defaults for the data-memory SRAM controller.
package dmem_sram_ctrl_pkg;

   localparam int unsigned DMEM_ADDR_W_DEF = 20;
   localparam logic [31:0] DMEM_BASE_DEF   = 32'h8040_0000;

   // Controller states; DONE is the single-cycle completion state
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_DONE     = 3'd5
   } dmem_state_e;

   // Latched store payload
   typedef struct packed {
      logic [3:0]  be_n;
      logic [31:0] data;
   } dmem_wr_t;

   // Wait-counter width: clog2 of the longer wait, at least one bit
   function automatic int unsigned dmem_cnt_w(input int unsigned rd_wait,
                                              input int unsigned wr_pulse);
      int unsigned m;
      m = (rd_wait > wr_pulse) ? rd_wait : wr_pulse;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/dmem_sram_ctrl.sv
// Data-memory responder: turns MEM-stage loads/stores into timed accesses
// on an external asynchronous 32-bit SRAM, stalling the pipeline meanwhile.
module dmem_sram_ctrl
   import dmem_sram_ctrl_pkg::*;
#(
   parameter int unsigned RD_WAIT   = 2,
   parameter int unsigned WR_PULSE  = 2,
   parameter int unsigned ADDR_W    = DMEM_ADDR_W_DEF,
   parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dm_valid_i,
   input  logic              dm_re_i,
   input  logic              dm_we_i,
   input  logic [31:0]       dm_addr_i,
   input  logic [3:0]        dm_wbe_n_i,
   input  logic [31:0]       dm_wdata_i,
   output logic [31:0]       dm_rdata_o,
   output logic              dm_stall_o,
   output logic [ADDR_W-1:0] ext_ram_addr_o,
   output logic [3:0]        ext_ram_be_n_o,
   output logic              ext_ram_ce_n_o,
   output logic              ext_ram_oe_n_o,
   output logic              ext_ram_we_n_o,
   output logic [31:0]       ext_ram_wdata_o,
   output logic              ext_ram_data_oe_o,
   input  logic [31:0]       ext_ram_rdata_i
);

   localparam int unsigned      CNT_W   = dmem_cnt_w(RD_WAIT, WR_PULSE);
   localparam int unsigned      WIN_LSB = ADDR_W + 2;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

   dmem_state_e       r_state;
   dmem_state_e       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [ADDR_W-1:0] r_addr;
   dmem_wr_t          r_wr;
   logic [31:0]       r_rdata;

   logic              r_ce_n;
   logic              r_oe_n;
   logic              r_we_n;
   logic              r_data_oe;
   logic [3:0]        r_be_n;

   logic              w_ce_n_nxt;
   logic              w_oe_n_nxt;
   logic              w_we_n_nxt;
   logic              w_data_oe_nxt;
   logic [3:0]        w_be_n_nxt;

   logic              w_req;
   logic              w_hit;
   logic              w_acc_rd;
   logic              w_acc_wr;
   logic              w_miss_rd;
   logic              w_latch;
   logic              w_capture;
   logic              w_stall_c;
   logic [3:0]        w_be_src;
   logic              w_unused;

   // Request decode; only meaningful while IDLE
   assign w_req     = dm_valid_i & (dm_re_i | dm_we_i);
   assign w_hit     = (dm_addr_i >> WIN_LSB) == (DMEM_BASE >> WIN_LSB);
   assign w_acc_rd  = (r_state == ST_IDLE) & w_req & ~dm_we_i & w_hit;
   assign w_acc_wr  = (r_state == ST_IDLE) & w_req & dm_we_i & w_hit & (dm_wbe_n_i != 4'hF);
   assign w_miss_rd = (r_state == ST_IDLE) & w_req & ~dm_we_i & ~w_hit;
   assign w_be_src  = (r_state == ST_IDLE) ? dm_wbe_n_i : r_wr.be_n;
   assign w_unused  = &{1'b0, dm_addr_i[1:0]};

   // Next state, wait counter, stall and next-cycle strobe values
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_latch       = 1'b0;
      w_capture     = 1'b0;
      w_stall_c     = 1'b0;
      w_ce_n_nxt    = 1'b1;
      w_oe_n_nxt    = 1'b1;
      w_we_n_nxt    = 1'b1;
      w_data_oe_nxt = 1'b0;
      w_be_n_nxt    = 4'hF;

      case (r_state)
         ST_IDLE: begin
            if (w_acc_rd) begin
               w_state_nxt = ST_RD;
               w_cnt_nxt   = RD_LOAD;
               w_latch     = 1'b1;
               w_stall_c   = 1'b1;
            end else if (w_acc_wr) begin
               w_state_nxt = ST_WR_SETUP;
               w_latch     = 1'b1;
               w_stall_c   = 1'b1;
            end
         end
         ST_RD: begin
            w_stall_c = 1'b1;
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_WR_SETUP: begin
            w_stall_c   = 1'b1;
            w_state_nxt = ST_WR_PULSE;
            w_cnt_nxt   = WR_LOAD;
         end
         ST_WR_PULSE: begin
            w_stall_c = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = ST_WR_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_WR_HOLD: begin
            w_stall_c   = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      case (w_state_nxt)
         ST_RD: begin
            w_ce_n_nxt = 1'b0;
            w_oe_n_nxt = 1'b0;
            w_be_n_nxt = 4'h0;
         end
         ST_WR_SETUP, ST_WR_HOLD: begin
            w_ce_n_nxt    = 1'b0;
            w_data_oe_nxt = 1'b1;
            w_be_n_nxt    = w_be_src;
         end
         ST_WR_PULSE: begin
            w_ce_n_nxt    = 1'b0;
            w_we_n_nxt    = 1'b0;
            w_data_oe_nxt = 1'b1;
            w_be_n_nxt    = w_be_src;
         end
         default: begin
            w_ce_n_nxt = 1'b1;
         end
      endcase
   end

   // State and wait-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request latch: the access is served only from this copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_wr   <= '{be_n: 4'hF, data: 32'h0};
      end else if (w_latch) begin
         r_addr <= dm_addr_i[ADDR_W+1:2];
         r_wr   <= '{be_n: dm_wbe_n_i, data: dm_wdata_i};
      end
   end

   // SRAM strobes, registered so nothing on dm_* reaches the pads combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_we_n    <= 1'b1;
         r_data_oe <= 1'b0;
         r_be_n    <= 4'hF;
      end else begin
         r_ce_n    <= w_ce_n_nxt;
         r_oe_n    <= w_oe_n_nxt;
         r_we_n    <= w_we_n_nxt;
         r_data_oe <= w_data_oe_nxt;
         r_be_n    <= w_be_n_nxt;
      end
   end

   // Load data capture at the end of the read wait
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 32'h0;
      end else if (w_capture) begin
         r_rdata <= ext_ram_rdata_i;
      end
   end

   // Stall is dropped immediately by reset so an aborted access releases the pipeline
   assign dm_stall_o        = rst_n & w_stall_c;
   assign dm_rdata_o        = w_miss_rd ? 32'h0 : r_rdata;
   assign ext_ram_addr_o    = r_addr;
   assign ext_ram_wdata_o   = r_wr.data;
   assign ext_ram_be_n_o    = r_be_n;
   assign ext_ram_ce_n_o    = r_ce_n;
   assign ext_ram_oe_n_o    = r_oe_n;
   assign ext_ram_we_n_o    = r_we_n;
   assign ext_ram_data_oe_o = r_data_oe;

endmodule
